// File: rtl/decode_pipe.sv
// ID/EX pipeline register for RV32I: decodes the fetched instruction, registers the controls,
// and handles the valid/ready handshake, load-use interlock, flush and JAL redirect.
module decode_pipe #(
    parameter int unsigned ADDRESS_BITS  = 16,
    parameter bit          HAZARD_DETECT = 1'b1,
    parameter logic [31:0] NOP           = 32'h00000013
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDRESS_BITS-1:0] PC,
    input  logic [31:0]             instruction,
    input  logic                    flush,
    input  logic [ADDRESS_BITS-1:0] flush_target,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDRESS_BITS-1:0] out_PC,
    output logic [4:0]              read_sel1,
    output logic [4:0]              read_sel2,
    output logic [4:0]              write_sel,
    output logic                    wEn,
    output logic                    branch_op,
    output logic                    op_B_sel,
    output logic                    mem_wEn,
    output logic                    wb_sel,
    output logic [1:0]              op_A_sel,
    output logic [5:0]              ALU_Control,
    output logic [31:0]             imm32,
    output logic                    redirect_valid,
    output logic [ADDRESS_BITS-1:0] redirect_PC
);

    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wen;
        logic        branch_op;
        logic        op_b_sel;
        logic        mem_wen;
        logic        wb_sel;
        logic [1:0]  op_a_sel;
        logic [5:0]  alu;
        logic [31:0] imm;
    } dec_t;

    // op_A_sel: 00 rs1, 01 PC, 10 PC+4, 11 zero. Writes to x0 never assert wEn.
    function automatic dec_t decode(input logic [31:0] ins);
        dec_t        d;
        logic        writes;
        logic [2:0]  f3;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        f3     = ins[14:12];
        imm_i  = {{20{ins[31]}}, ins[31:20]};
        imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        imm_u  = {ins[31:12], 12'd0};
        imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        d      = '0;
        writes = 1'b0;
        d.rs1  = ins[19:15];
        d.rs2  = ins[24:20];
        d.rd   = ins[11:7];
        case (ins[6:0])
            OpReg: begin
                writes = 1'b1;
                d.alu  = {2'b00, ins[30], f3};
            end
            OpImm: begin
                writes     = 1'b1;
                d.op_b_sel = 1'b1;
                d.imm      = imm_i;
                d.alu      = (f3 == 3'b101) ? {2'b00, ins[30], f3} : {3'b000, f3};
            end
            OpLoad: begin
                writes     = 1'b1;
                d.op_b_sel = 1'b1;
                d.wb_sel   = 1'b1;
                d.imm      = imm_i;
            end
            OpStore: begin
                d.op_b_sel = 1'b1;
                d.mem_wen  = 1'b1;
                d.imm      = imm_s;
            end
            OpBranch: begin
                d.branch_op = 1'b1;
                d.alu       = {3'b010, f3};
                d.imm       = imm_b;
            end
            OpJal: begin
                writes     = 1'b1;
                d.op_a_sel = 2'b10;
                d.alu      = 6'b011111;
                d.imm      = imm_j;
            end
            OpJalr: begin
                writes     = 1'b1;
                d.op_a_sel = 2'b10;
                d.alu      = 6'b111111;
                d.imm      = imm_i;
            end
            OpLui: begin
                writes     = 1'b1;
                d.op_a_sel = 2'b11;
                d.op_b_sel = 1'b1;
                d.imm      = imm_u;
            end
            OpAuipc: begin
                writes     = 1'b1;
                d.op_a_sel = 2'b01;
                d.op_b_sel = 1'b1;
                d.imm      = imm_u;
            end
            default: ;
        endcase
        d.wen = writes & (d.rd != 5'd0);
        return d;
    endfunction

    dec_t                    in_dec, nop_dec, dec_q, dec_d;
    logic                    out_valid_q, out_valid_d;
    logic                    redirect_valid_q, redirect_valid_d;
    logic [ADDRESS_BITS-1:0] out_pc_q, out_pc_d, redirect_pc_q, redirect_pc_d;
    logic                    uses_rs2, hazard, accept, issue, is_jal;

    always_comb begin
        in_dec   = decode(instruction);
        nop_dec  = decode(NOP);
        is_jal   = (instruction[6:0] == OpJal);
        uses_rs2 = (instruction[6:0] == OpReg) || (instruction[6:0] == OpStore) ||
                   (instruction[6:0] == OpBranch);
    end

    // Only loads (wb_sel) produce their result too late to forward into the next instruction.
    always_comb begin
        hazard = HAZARD_DETECT && out_valid_q && dec_q.wb_sel && (dec_q.rd != 5'd0) &&
                 ((dec_q.rd == in_dec.rs1) || (uses_rs2 && (dec_q.rd == in_dec.rs2)));
        in_ready = ~reset & ~flush & ~redirect_valid_q & (~out_valid_q | out_ready) & ~hazard;
        accept   = in_valid & in_ready;
        issue    = out_valid_q & out_ready;
    end

    always_comb begin
        dec_d            = dec_q;
        out_pc_d         = out_pc_q;
        out_valid_d      = out_valid_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        if (flush) begin
            out_valid_d      = 1'b0;
            redirect_valid_d = 1'b1;
            redirect_pc_d    = flush_target;
        end else if (accept) begin
            dec_d       = in_dec;
            out_pc_d    = PC;
            out_valid_d = 1'b1;
            if (is_jal) begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = PC + in_dec.imm[ADDRESS_BITS-1:0];
            end
        end else if (issue) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dec_q            <= nop_dec;
            out_pc_q         <= '0;
            out_valid_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            dec_q            <= dec_d;
            out_pc_q         <= out_pc_d;
            out_valid_q      <= out_valid_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_PC         = out_pc_q;
    assign read_sel1      = dec_q.rs1;
    assign read_sel2      = dec_q.rs2;
    assign write_sel      = dec_q.rd;
    assign wEn            = dec_q.wen;
    assign branch_op      = dec_q.branch_op;
    assign op_B_sel       = dec_q.op_b_sel;
    assign mem_wEn        = dec_q.mem_wen;
    assign wb_sel         = dec_q.wb_sel;
    assign op_A_sel       = dec_q.op_a_sel;
    assign ALU_Control    = dec_q.alu;
    assign imm32          = dec_q.imm;
    assign redirect_valid = redirect_valid_q;
    assign redirect_PC    = redirect_pc_q;

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: decode vector table, directed handshake/hazard/flush/JAL sequences,
// and a randomized load/add stream checked against an in-order transaction model.
module tb_decode_pipe;

    logic        clock = 1'b0;
    logic        reset, in_valid, out_ready, flush;
    logic [15:0] PC, flush_target;
    logic [31:0] instruction;

    logic        in_ready, out_valid, wEn, branch_op, op_B_sel, mem_wEn, wb_sel, redirect_valid;
    logic [15:0] out_PC, redirect_PC;
    logic [4:0]  read_sel1, read_sel2, write_sel;
    logic [1:0]  op_A_sel;
    logic [5:0]  ALU_Control;
    logic [31:0] imm32;

    logic        n_in_ready, n_out_valid, n_wEn, n_branch_op, n_op_B_sel, n_mem_wEn, n_wb_sel;
    logic        n_redirect_valid;
    logic [15:0] n_out_PC, n_redirect_PC;
    logic [4:0]  n_read_sel1, n_read_sel2, n_write_sel;
    logic [1:0]  n_op_A_sel;
    logic [5:0]  n_ALU_Control;
    logic [31:0] n_imm32;

    decode_pipe #(.ADDRESS_BITS(16), .HAZARD_DETECT(1'b1), .NOP(32'h00000013)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .PC(PC),
        .instruction(instruction), .flush(flush), .flush_target(flush_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_PC(out_PC), .read_sel1(read_sel1),
        .read_sel2(read_sel2), .write_sel(write_sel), .wEn(wEn), .branch_op(branch_op),
        .op_B_sel(op_B_sel), .mem_wEn(mem_wEn), .wb_sel(wb_sel), .op_A_sel(op_A_sel),
        .ALU_Control(ALU_Control), .imm32(imm32), .redirect_valid(redirect_valid),
        .redirect_PC(redirect_PC)
    );

    decode_pipe #(.ADDRESS_BITS(16), .HAZARD_DETECT(1'b0), .NOP(32'h00000013)) dut_nh (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(n_in_ready), .PC(PC),
        .instruction(instruction), .flush(flush), .flush_target(flush_target),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_PC(n_out_PC),
        .read_sel1(n_read_sel1), .read_sel2(n_read_sel2), .write_sel(n_write_sel),
        .wEn(n_wEn), .branch_op(n_branch_op), .op_B_sel(n_op_B_sel), .mem_wEn(n_mem_wEn),
        .wb_sel(n_wb_sel), .op_A_sel(n_op_A_sel), .ALU_Control(n_ALU_Control),
        .imm32(n_imm32), .redirect_valid(n_redirect_valid), .redirect_PC(n_redirect_PC)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [4:0]  rs1, rs2, rd;
        logic        wen, br, opb, mw, wb;
        logic [1:0]  opa;
        logic [5:0]  alu;
        logic [31:0] imm;
    } vec_t;

    typedef struct {
        logic [15:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic        ld;
    } item_t;

    localparam logic [31:0] AddiA1 = 32'hFFF00593;  // addi a1,zero,-1
    localparam logic [31:0] AddA6  = 32'h00C58833;  // add a6,a1,a2
    localparam logic [31:0] LwS2   = 32'h0005A903;  // lw s2,0(a1)
    localparam logic [31:0] AddDep = 32'h00C90833;  // add a6,s2,a2
    localparam logic [31:0] Jal20  = 32'h0140006F;  // jal x0,+20
    localparam logic [31:0] XorA4  = 32'h00F5C733;  // xor a4,a1,a5

    vec_t  vecs[11];
    item_t q[$];
    item_t cur, e;
    int    last_cyc;
    logic  last_ld;
    logic [4:0] last_rd;

    initial begin
        vecs[0]  = '{AddiA1,       0, 31, 11, 1, 0, 1, 0, 0, 2'b00, 6'b000000, 32'hFFFFFFFF};
        vecs[1]  = '{32'h407302B3, 6,  7,  5, 1, 0, 0, 0, 0, 2'b00, 6'b001000, 32'h0};
        vecs[2]  = '{32'h40355513, 10, 3, 10, 1, 0, 1, 0, 0, 2'b00, 6'b001101, 32'h403};
        vecs[3]  = '{32'h00C5A423, 11, 12, 8, 0, 0, 1, 1, 0, 2'b00, 6'b000000, 32'h8};
        vecs[4]  = '{32'hFEB50EE3, 10, 11, 29, 0, 1, 0, 0, 0, 2'b00, 6'b010000, 32'hFFFFFFFC};
        vecs[5]  = '{32'h000280E7, 5,  0,  1, 1, 0, 0, 0, 0, 2'b10, 6'b111111, 32'h0};
        vecs[6]  = '{32'h123457B7, 8,  3, 15, 1, 0, 1, 0, 0, 2'b11, 6'b000000, 32'h12345000};
        vecs[7]  = '{32'h00001197, 0,  0,  3, 1, 0, 1, 0, 0, 2'b01, 6'b000000, 32'h1000};
        vecs[8]  = '{LwS2,         11, 0, 18, 1, 0, 1, 0, 1, 2'b00, 6'b000000, 32'h0};
        vecs[9]  = '{Jal20,        0, 20,  0, 0, 0, 0, 0, 0, 2'b10, 6'b011111, 32'h14};
        vecs[10] = '{XorA4,        11, 15, 14, 1, 0, 0, 0, 0, 2'b00, 6'b000100, 32'h0};

        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
        PC = 16'h0; flush_target = 16'h0; instruction = AddiA1;
        tick;
        chk("reset_in_ready", in_ready, 0);
        tick;
        in_valid = 1'b0;
        reset    = 1'b0;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_redirect_valid", redirect_valid, 0);
        chk("reset_redirect_PC", redirect_PC, 0);
        chk("reset_out_PC", out_PC, 0);
        chk("reset_write_sel", write_sel, 0);
        chk("reset_wEn", wEn, 0);
        chk("reset_mem_wEn", mem_wEn, 0);

        // 1: addi a1,zero,-1, latency one
        in_valid = 1'b1; out_ready = 1'b1; PC = 16'h0100; instruction = AddiA1;
        tick;
        chk("t1_out_valid", out_valid, 1);
        chk("t1_write_sel", write_sel, 11);
        chk("t1_imm32", imm32, 32'hFFFFFFFF);
        chk("t1_wEn", wEn, 1);

        // 2: back-pressure holds everything
        out_ready = 1'b0; PC = 16'h0104; instruction = AddA6;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("t2_in_ready", in_ready, 0);
            chk("t2_out_valid", out_valid, 1);
            chk("t2_write_sel", write_sel, 11);
            chk("t2_out_PC", out_PC, 16'h0100);
            tick;
        end
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("t2_add_valid", out_valid, 1);
        chk("t2_read_sel1", read_sel1, 11);
        chk("t2_read_sel2", read_sel2, 12);
        chk("t2_out_PC_add", out_PC, 16'h0104);

        // 3: load-use bubble; no bubble without hazard detection
        in_valid = 1'b1; PC = 16'h0108; instruction = LwS2;
        tick;
        PC = 16'h010C; instruction = AddDep;
        #1;
        chk("t3_in_ready_stall", in_ready, 0);
        chk("t3_nh_in_ready", n_in_ready, 1);
        tick;
        chk("t3_bubble", out_valid, 0);
        chk("t3_nh_back_to_back", n_out_valid, 1);
        chk("t3_nh_write_sel", n_write_sel, 16);
        tick;
        in_valid = 1'b0;
        chk("t3_consumer_valid", out_valid, 1);
        chk("t3_consumer_rs1", read_sel1, 18);
        chk("t3_consumer_PC", out_PC, 16'h010C);

        // 4: JAL redirect
        in_valid = 1'b1; PC = 16'h0114; instruction = Jal20;
        tick;
        PC = 16'h0118; instruction = AddiA1;
        #1;
        chk("t4_redirect_valid", redirect_valid, 1);
        chk("t4_redirect_PC", redirect_PC, 16'h0128);
        chk("t4_in_ready", in_ready, 0);
        chk("t4_jal_registered", out_valid, 1);
        tick;
        in_valid = 1'b0;
        chk("t4_redirect_pulse", redirect_valid, 0);
        chk("t4_wrong_path_dropped", out_valid, 0);

        // 5: flush
        in_valid = 1'b1; PC = 16'h0150; instruction = XorA4;
        tick;
        out_ready = 1'b0; flush = 1'b1; flush_target = 16'h0154;
        PC = 16'h0158; instruction = AddiA1;
        #1;
        chk("t5_in_ready", in_ready, 0);
        tick;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_redirect_valid", redirect_valid, 1);
        chk("t5_redirect_PC", redirect_PC, 16'h0154);
        tick;
        chk("t5_redirect_pulse", redirect_valid, 0);
        chk("t5_not_accepted", out_valid, 0);

        // 6: reset during a load-use stall
        in_valid = 1'b1; PC = 16'h0160; instruction = LwS2;
        tick;
        PC = 16'h0164; instruction = AddDep;
        #1;
        chk("t6_stalled", in_ready, 0);
        reset = 1'b1;
        tick;
        chk("t6_out_valid", out_valid, 0);
        chk("t6_redirect_valid", redirect_valid, 0);
        chk("t6_wEn", wEn, 0);
        chk("t6_write_sel", write_sel, 0);
        reset = 1'b0; in_valid = 1'b0;
        tick;

        // Decode table
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            instruction = vecs[i].ins;
            PC          = 16'(16'h0200 + i * 4);
            in_valid    = 1'b1;
            tick;
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid", i), out_valid, 1);
            chk($sformatf("v%0d_PC", i), out_PC, 16'(16'h0200 + i * 4));
            chk($sformatf("v%0d_rs1", i), read_sel1, vecs[i].rs1);
            chk($sformatf("v%0d_rs2", i), read_sel2, vecs[i].rs2);
            chk($sformatf("v%0d_rd", i), write_sel, vecs[i].rd);
            chk($sformatf("v%0d_wEn", i), wEn, vecs[i].wen);
            chk($sformatf("v%0d_branch", i), branch_op, vecs[i].br);
            chk($sformatf("v%0d_opB", i), op_B_sel, vecs[i].opb);
            chk($sformatf("v%0d_memw", i), mem_wEn, vecs[i].mw);
            chk($sformatf("v%0d_wb", i), wb_sel, vecs[i].wb);
            chk($sformatf("v%0d_opA", i), op_A_sel, vecs[i].opa);
            chk($sformatf("v%0d_alu", i), ALU_Control, vecs[i].alu);
            chk($sformatf("v%0d_imm", i), imm32, vecs[i].imm);
            tick;
            tick;
        end

        // Random load/add stream: issued order must equal accepted order, and a consumer of a
        // load may never issue on the cycle right after that load.
        last_ld = 1'b0; last_rd = 5'd0; last_cyc = 0;
        for (int i = 0; i < 600; i++) begin
            tick;
            cur.ld  = 1'($urandom_range(0, 1));
            cur.rd  = 5'($urandom_range(0, 3));
            cur.rs1 = 5'($urandom_range(0, 3));
            cur.rs2 = cur.ld ? 5'd0 : 5'($urandom_range(0, 3));
            cur.pc  = 16'($urandom_range(0, 16383) * 4);
            instruction = cur.ld ? {12'd0, cur.rs1, 3'b010, cur.rd, 7'b0000011}
                                 : {7'd0, cur.rs2, cur.rs1, 3'b000, cur.rd, 7'b0110011};
            PC        = cur.pc;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            if (out_valid && !out_ready) chk("rand_hold_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rand_issue: got an issue, expected none (nothing accepted)");
                end else begin
                    e = q.pop_front();
                    chk("rand_PC", out_PC, e.pc);
                    chk("rand_rd", write_sel, e.rd);
                    chk("rand_rs1", read_sel1, e.rs1);
                    chk("rand_rs2", read_sel2, e.rs2);
                    chk("rand_wb_sel", wb_sel, e.ld);
                    if (last_ld && last_rd != 0 &&
                        (e.rs1 == last_rd || (!e.ld && e.rs2 == last_rd)))
                        chk("rand_load_use_gap", 32'((i - last_cyc) >= 2), 1);
                    last_ld  = e.ld;
                    last_rd  = e.rd;
                    last_cyc = i;
                end
            end
            if (in_valid && in_ready) q.push_back(cur);
        end
        tick;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (out_valid && q.size() != 0) begin
                e = q.pop_front();
                chk("drain_PC", out_PC, e.pc);
            end
            tick;
        end
        chk("drain_empty", q.size(), 0);
        chk("drain_out_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
